// File: rtl/de1_io_pkg.sv
// Shared types and constants for the DE1 pushbutton/switch input path.
// Channel state encoding, a constant-foldable clog2, and board-clock debounce defaults.
package de1_io_pkg;

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_CHK_DN = 2'd1,
    ST_DOWN   = 2'd2,
    ST_CHK_UP = 2'd3
  } ch_state_t;

  // Prescale values giving a 1 ms debounce tick for each DE1 oscillator.
  localparam int PRESCALE_24MHZ   = 24000;
  localparam int PRESCALE_27MHZ   = 27000;
  localparam int PRESCALE_50MHZ   = 50000;
  localparam int DEBOUNCE_DEFAULT = 20;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int cnt_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/de1_key_debounce_ch.sv
// One input channel: two-flop synchronizer, polarity normalisation and a
// tick-driven debounce FSM producing a clean level plus press/release pulses.
module de1_key_debounce_ch
  import de1_io_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE   = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic tick_i,
  output logic key_o,
  output logic press_o,
  output logic release_o
);

  localparam int                 TCNT_W    = cnt_width(DEBOUNCE);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(DEBOUNCE - 1);

  logic              sync1;
  logic              sync2;
  logic              pressed;
  ch_state_t         state;
  logic [TCNT_W-1:0] tcnt;

  // NOTE: the synchronizer resets to the released pin level, so a button held
  // through reset shows up as a fresh edge and is debounced again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= key_i;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_UP;
      tcnt      <= '0;
      key_o     <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so each lasts exactly one clock.
      press_o   <= 1'b0;
      release_o <= 1'b0;
      unique case (state)
        ST_UP: begin
          if (pressed) begin
            state <= ST_CHK_DN;
            tcnt  <= '0;
          end
        end
        ST_CHK_DN: begin
          if (!pressed) begin
            state <= ST_UP;
          end else if (tick_i) begin
            if (tcnt == TCNT_LAST) begin
              state   <= ST_DOWN;
              key_o   <= 1'b1;
              press_o <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        ST_DOWN: begin
          if (!pressed) begin
            state <= ST_CHK_UP;
            tcnt  <= '0;
          end
        end
        ST_CHK_UP: begin
          if (pressed) begin
            state <= ST_DOWN;
          end else if (tick_i) begin
            if (tcnt == TCNT_LAST) begin
              state     <= ST_UP;
              key_o     <= 1'b0;
              release_o <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= ST_UP;
      endcase
    end
  end

endmodule

// File: rtl/de1_key_reader.sv
// DE1 KEY/SW reader: shared debounce prescaler, N debounced channels and a
// wrapping count of accepted presses across all channels.
module de1_key_reader
  import de1_io_pkg::*;
#(
  parameter int N          = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int PRESCALE   = PRESCALE_24MHZ,
  parameter int DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     key_i,
  input  logic             clear_i,
  output logic [N-1:0]     key_o,
  output logic [N-1:0]     press_o,
  output logic [N-1:0]     release_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int                PCNT_W    = cnt_width(PRESCALE);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt;
  logic [CNT_W-1:0]  press_cnt;

  always_ff @(posedge clk) begin
    if (rst)                    pcnt <= '0;
    else if (pcnt == PCNT_LAST) pcnt <= '0;
    else                        pcnt <= pcnt + 1'b1;
  end

  // Decoded from the registered count; with PRESCALE=1 it is high every cycle.
  assign tick_o = (pcnt == PCNT_LAST);

  for (genvar g = 0; g < N; g++) begin : g_ch
    de1_key_debounce_ch #(
      .ACTIVE_LOW(ACTIVE_LOW),
      .DEBOUNCE  (DEBOUNCE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_i    (key_i[g]),
      .tick_i   (tick_o),
      .key_o    (key_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g])
    );
  end

  // NOTE: always_comb outputs get a default first so no latch can be inferred.
  always_comb begin
    press_cnt = '0;
    for (int i = 0; i < N; i++) press_cnt = press_cnt + CNT_W'(press_o[i]);
  end

  // Clear restarts from this cycle's presses so none are lost.
  always_ff @(posedge clk) begin
    if (rst)          count_o <= '0;
    else if (clear_i) count_o <= press_cnt;
    else              count_o <= count_o + press_cnt;
  end

endmodule

// File: tb/tb_de1_key_reader.sv
// Bench for de1_key_reader: a cycle model built from the debounce rules is
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_de1_key_reader;

  localparam int N          = 4;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int PRESCALE   = 4;
  localparam int DEBOUNCE   = 3;
  localparam int CNT_W      = 8;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic [N-1:0]     key_i   = '1;
  logic             clear_i = 1'b0;
  logic [N-1:0]     key_o;
  logic [N-1:0]     press_o;
  logic [N-1:0]     release_o;
  logic             tick_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk = ~clk;

  de1_key_reader #(
    .N(N), .ACTIVE_LOW(ACTIVE_LOW), .PRESCALE(PRESCALE),
    .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_i),
    .clear_i  (clear_i),
    .key_o    (key_o),
    .press_o  (press_o),
    .release_o(release_o),
    .tick_o   (tick_o),
    .count_o  (count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Behavioural model: a level is accepted once the synchronized input has
  // disagreed with it on every edge of a run and DEBOUNCE ticks have fallen
  // on that run after its first edge.
  bit               model_valid = 1'b0;
  int               m_cyc;
  bit [N-1:0]       m_p1, m_p2, m_level, m_press, m_rel;
  int               m_run   [N];
  int               m_ticks [N];
  bit [CNT_W-1:0]   m_count;
  bit               m_tick_now;
  int               m_pop;

  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      m_cyc   = 0;
      m_p1    = '0;
      m_p2    = '0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_count = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]   = 0;
        m_ticks[i] = 0;
      end
    end else if (model_valid) begin
      m_tick_now = (m_cyc % PRESCALE) == PRESCALE - 1;
      m_pop      = $countones(m_press);
      m_count    = clear_i ? CNT_W'(m_pop) : m_count + CNT_W'(m_pop);
      m_press    = '0;
      m_rel      = '0;
      for (int i = 0; i < N; i++) begin
        if (m_p2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] > 1 && m_tick_now) m_ticks[i]++;
          if (m_ticks[i] == DEBOUNCE) begin
            m_level[i] = m_p2[i];
            if (m_p2[i]) m_press[i] = 1'b1;
            else         m_rel[i]   = 1'b1;
            m_run[i]   = 0;
            m_ticks[i] = 0;
          end
        end else begin
          m_run[i]   = 0;
          m_ticks[i] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = ACTIVE_LOW ? ~key_i : key_i;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("key_o",     key_o,     m_level);
      check("press_o",   press_o,   m_press);
      check("release_o", release_o, m_rel);
      check("tick_o",    tick_o,    ((m_cyc % PRESCALE) == PRESCALE - 1));
      check("count_o",   count_o,   m_count);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name, input bit want_rel, input logic [N-1:0] mask,
                            input int bound);
    bit found;
    found = 1'b0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (((want_rel ? release_o : press_o) & mask) == mask) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, found, 1'b1);
    #1;
  endtask

  // Starting in cycle 1 after a reset, returns the cycle of the first press_o[0].
  task automatic find_press0(input string name, input int expect_cycle);
    int first;
    bit rel_seen;
    first    = 0;
    rel_seen = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (press_o[0] && first == 0) first = k;
      if (release_o != '0) rel_seen = 1'b1;
    end
    check({name, "_press_cycle"}, first, expect_cycle);
    check({name, "_no_release"}, rel_seen, 1'b0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset, all keys released; ticks in cycles 4, 8, 12
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      check("t1_tick_literal", tick_o, (k % 4 == 0));
    end
    cycles(38);
    check("t1_key_idle", key_o, 4'h0);
    check("t1_count_idle", count_o, 8'd0);

    // 2: single press and release on key 0
    key_i[0] = 1'b0;
    wait_pulse("t2_press", 1'b0, 4'b0001, 40);
    check("t2_key_with_press", key_o, 4'b0001);
    cycles(1);
    check("t2_count_after_press", count_o, 8'd1);
    cycles(20);
    key_i[0] = 1'b1;
    wait_pulse("t2_release", 1'b1, 4'b0001, 40);
    check("t2_key_with_release", key_o, 4'b0000);
    cycles(1);
    check("t2_count_after_release", count_o, 8'd1);

    // 3: six-cycle glitch on key 1 is rejected
    key_i[1] = 1'b0;
    cycles(6);
    key_i[1] = 1'b1;
    cycles(40);
    check("t3_key_glitch", key_o, 4'h0);
    check("t3_count_glitch", count_o, 8'd1);

    // 4: all keys at once, then again with a coincident clear
    key_i = '0;
    wait_pulse("t4_press_all", 1'b0, 4'hF, 40);
    cycles(1);
    check("t4_count_plus4", count_o, 8'd5);
    cycles(20);
    key_i = '1;
    wait_pulse("t4_release_all", 1'b1, 4'hF, 40);
    cycles(20);
    key_i = '0;
    wait_pulse("t4_press_clear", 1'b0, 4'hF, 40);
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    check("t4_count_clear", count_o, 8'd4);
    cycles(20);
    key_i = '1;
    wait_pulse("t4_release_clear", 1'b1, 4'hF, 40);
    cycles(20);

    // 5: 256 presses on key 2 wrap the counter, one more gives 1
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    check("t5_count_cleared", count_o, 8'd0);
    for (int r = 0; r < 256; r++) begin
      key_i[2] = 1'b0;
      wait_pulse("t5_press", 1'b0, 4'b0100, 40);
      cycles(3);
      key_i[2] = 1'b1;
      wait_pulse("t5_release", 1'b1, 4'b0100, 40);
      cycles(2);
    end
    check("t5_count_wrapped", count_o, 8'd0);
    key_i[2] = 1'b0;
    wait_pulse("t5_press_extra", 1'b0, 4'b0100, 40);
    cycles(1);
    check("t5_count_one", count_o, 8'd1);
    key_i[2] = 1'b1;
    wait_pulse("t5_release_extra", 1'b1, 4'b0100, 40);
    cycles(5);

    // 6: reset in CHK_DN, then in DOWN, key 0 held throughout
    key_i[0] = 1'b0;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("t6_chk_key_zero", key_o, 4'h0);
    check("t6_chk_count_zero", count_o, 8'd0);
    find_press0("t6_after_chk", 13);
    check("t6_held_down", key_o, 4'b0001);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("t6_down_key_zero", key_o, 4'h0);
    check("t6_down_no_release", release_o, 4'h0);
    find_press0("t6_after_down", 13);
    key_i[0] = 1'b1;
    wait_pulse("t6_release", 1'b1, 4'b0001, 40);
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
